// File: rtl/sfx_pkg.sv
// Shared types and envelope tables for the square-wave sound-effect sequencer.
package sfx_pkg;

    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

    localparam int DUTY_W = 19;

    localparam logic [DUTY_W-1:0] ENV_FALL [16] = '{
        19'd37878, 19'd33842, 19'd30208, 19'd26940, 19'd24008, 19'd21383, 19'd19043, 19'd16966,
        19'd15135, 19'd13530, 19'd12132, 19'd10924, 19'd9879,  19'd8932,  19'd8076,  19'd7300
    };

    localparam logic [DUTY_W-1:0] ENV_RISE [16] = '{
        19'd7300,  19'd8076,  19'd8932,  19'd9879,  19'd10924, 19'd12132, 19'd13530, 19'd15135,
        19'd16966, 19'd19043, 19'd21383, 19'd24008, 19'd26940, 19'd30208, 19'd33842, 19'd37878
    };

    // Only effect 1 rises; every other id shares the falling table.
    function automatic logic [DUTY_W-1:0] sfx_duty(input logic [1:0] id, input logic [3:0] stage);
        return (id == 2'd1) ? ENV_RISE[stage] : ENV_FALL[stage];
    endfunction

endpackage

// File: rtl/sfx_frame_timer.sv
// Frame counter, envelope stage and pass counter; exposes next-state values so the
// top can register the waveform from the values being loaded.
module sfx_frame_timer #(
    parameter int CNT_W   = 19,
    parameter int PERIOD  = 200000,
    parameter int STAGES  = 16,
    parameter int REPEATS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic [3:0]       stage_nxt,
    output logic             last_cycle
);
    localparam int REP_W = (REPEATS > 1) ? $clog2(REPEATS) : 1;

    logic [CNT_W-1:0] counter;
    logic [3:0]       stage;
    logic [REP_W-1:0] rep, rep_nxt;
    logic             frame_wrap, last_stage, last_rep;

    assign frame_wrap = (counter == CNT_W'(PERIOD - 1));
    assign last_stage = (stage == 4'(STAGES - 1));
    assign last_rep   = (rep == REP_W'(REPEATS - 1));
    assign last_cycle = frame_wrap && last_stage && last_rep;

    always_comb begin
        cnt_nxt   = counter;
        stage_nxt = stage;
        rep_nxt   = rep;
        if (clear) begin
            cnt_nxt   = '0;
            stage_nxt = '0;
            rep_nxt   = '0;
        end else if (advance) begin
            if (frame_wrap) begin
                cnt_nxt = '0;
                if (last_stage) begin
                    stage_nxt = '0;
                    rep_nxt   = rep + REP_W'(1);
                end else begin
                    stage_nxt = stage + 4'd1;
                end
            end else begin
                cnt_nxt = counter + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            counter <= '0;
            stage   <= '0;
            rep     <= '0;
        end else begin
            counter <= cnt_nxt;
            stage   <= stage_nxt;
            rep     <= rep_nxt;
        end
    end

endmodule

// File: rtl/sfx_sequencer.sv
// Priority-arbitrated enveloped square-wave effect player.
// Define SFX_PREEMPT_EN to let an equal-or-higher trigger restart a playing effect.
module sfx_sequencer
    import sfx_pkg::*;
#(
    parameter int CNT_W   = 19,
    parameter int PERIOD  = 200000,
    parameter int STAGES  = 16,
    parameter int REPEATS = 2,
    parameter int NUM_SFX = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SFX-1:0] trig,
    output logic               wave_out,
    output logic               busy,
    output logic [1:0]         sfx_id,
    output logic               done
);
    localparam int CMP_W = (CNT_W > DUTY_W) ? CNT_W : DUTY_W;

    if (PERIOD > 2**CNT_W || PERIOD < 1) begin : g_bad_period
        $error("sfx_sequencer: PERIOD must be in 1..2**CNT_W");
    end
    if (STAGES < 1 || STAGES > 16 || REPEATS < 1 || NUM_SFX < 1 || NUM_SFX > 4) begin : g_bad_cfg
        $error("sfx_sequencer: STAGES/REPEATS/NUM_SFX out of range");
    end

    state_t           state, state_nxt;
    logic [1:0]       id_nxt, trig_hi;
    logic             trig_any, preempt, clear, advance, last_cycle;
    logic [CNT_W-1:0] cnt_nxt;
    logic [3:0]       stage_nxt;

    assign trig_any = |trig;

    always_comb begin
        trig_hi = '0;
        for (int i = 0; i < NUM_SFX; i++)
            if (trig[i]) trig_hi = 2'(i);
    end

`ifdef SFX_PREEMPT_EN
    assign preempt = trig_any && (trig_hi >= sfx_id);
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        id_nxt    = sfx_id;
        clear     = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                clear = 1'b1;
                if (trig_any) begin
                    state_nxt = PLAY;
                    id_nxt    = trig_hi;
                end
            end
            PLAY: begin
                if (preempt) begin
                    clear  = 1'b1;
                    id_nxt = trig_hi;
                end else if (last_cycle) begin
                    state_nxt = DONE;
                    clear     = 1'b1;
                end else begin
                    advance = 1'b1;
                end
            end
            DONE: begin
                clear     = 1'b1;
                state_nxt = trig_any ? PLAY : IDLE;
                if (trig_any) id_nxt = trig_hi;
            end
            default: begin
                clear     = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    sfx_frame_timer #(
        .CNT_W   (CNT_W),
        .PERIOD  (PERIOD),
        .STAGES  (STAGES),
        .REPEATS (REPEATS)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .advance    (advance),
        .cnt_nxt    (cnt_nxt),
        .stage_nxt  (stage_nxt),
        .last_cycle (last_cycle)
    );

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            sfx_id   <= '0;
            wave_out <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            sfx_id   <= id_nxt;
            wave_out <= (state_nxt == PLAY) &&
                        (CMP_W'(cnt_nxt) < CMP_W'(sfx_duty(id_nxt, stage_nxt)));
            busy     <= (state_nxt == PLAY);
            done     <= (state_nxt == DONE);
        end
    end

endmodule
